frame_draw_scheduler: RTL
=========================

Name: frame_draw_scheduler

Overview:
- Sits between the game FSM/timers and the full-screen image drawer.
- Collects redraw requests for the seven whack frames, picks one by fixed priority, and drives the drawer's frame select and enable.
- Waits for the drawer to report completion, enforces a minimum on-screen hold time, and flags drawer hangs with a watchdog.

Parameters:
- NUM_FRAMES, 7, number of frame request lines (frame IDs 0..NUM_FRAMES-1).
- FRAME_W, 3, width of frame ID.
- SETUP_CYCLES, 2, cycles frame select is held stable before enable (ROM latency settle); legal 1..255.
- HOLD_CYCLES, 1000, minimum cycles after a completed draw before the next grant; 0 = no hold.
- TIMEOUT_CYCLES, 20000, maximum DRAW cycles before abort (one 160x120 pass is 19200).
- CNT_W, 16, shared counter width; must hold max(SETUP_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous reset, active-high.
- iReq  in  NUM_FRAMES  per-frame redraw request; a one-cycle pulse is sufficient.
- iDrawDone  in  1  one-cycle pulse from the drawer at the end of the last pixel.
- iClearErr  in  1  clears oTimeout.
- oFrameSel  out  FRAME_W  frame ID the drawer must render.
- oDrawEnable  out  1  drawer enable; high for the whole DRAW state.
- oBusy  out  1  high in every state except IDLE.
- oShownFrame  out  FRAME_W  last frame drawn to completion.
- oShownValid  out  1  oShownFrame is meaningful.
- oTimeout  out  1  sticky watchdog error.

Behaviour:
- Reset (async, any state): state=IDLE, pend=0, counter=0. All outputs 0, including oFrameSel, oShownFrame, oShownValid and oTimeout.
- Pending register: pend <= (pend | iReq) & ~grant_onehot. If a bit is re-requested in its own grant cycle, the new request wins and the bit stays set.
- Arbitration: highest ID wins (GameOver=6 over Mole4..Mole1 over Game over Start=0). Arbitration input is pend|iReq, so a request is seen in the same cycle it arrives.
- States:
  - IDLE: if pend|iReq is nonzero at an edge, latch the winner into oFrameSel, clear its pend bit, counter=0, go to SETUP.
  - SETUP: oDrawEnable=0, oFrameSel stable. After SETUP_CYCLES cycles, go to DRAW with counter=0.
  - DRAW: oDrawEnable=1, counter increments.
    - iDrawDone: oShownFrame<=oFrameSel, oShownValid<=1. Go to HOLD with counter=0, or to IDLE if HOLD_CYCLES=0.
    - Otherwise, when counter reaches TIMEOUT_CYCLES-1: oTimeout<=1, go to IDLE. oShownFrame is unchanged; the granted request is not re-queued.
    - iDrawDone in the same cycle as timeout: done wins and no error is set.
  - HOLD: after HOLD_CYCLES cycles, go to IDLE. Requests keep accumulating in pend during HOLD.
- Latency: iReq sampled at edge N gives oFrameSel valid after N. oDrawEnable rises after edge N+SETUP_CYCLES.
- iDrawDone outside DRAW is ignored.
- oFrameSel only changes on a grant; it holds its value in IDLE.
- oTimeout clears on iClearErr. If iClearErr and a new timeout occur in the same cycle, the set wins.
- Requests with index >= NUM_FRAMES do not exist; a width mismatch is a lint error.

Optional Feature:
- Macro: FRAME_DEDUP_EN.
- Defined: in IDLE, if the winner equals oShownFrame and oShownValid=1, clear its pend bit without drawing and stay in IDLE. The next arbitration happens on the following cycle.
- Undefined: every request causes a full redraw.

Decomposition:
- Package whack_draw_pkg:
  - Frame ID localparams FRM_START=0, FRM_GAME=1, FRM_MOLE1..FRM_MOLE4=2..5, FRM_GAMEOVER=6.
  - State encoding S_IDLE, S_SETUP, S_DRAW, S_HOLD.
  - FRAME_W.
- One sub-module: draw_priority_enc. Combinational NUM_FRAMES-bit highest-index encoder producing a valid bit, a binary ID and a one-hot grant.

Test Plan (SETUP_CYCLES=2, HOLD_CYCLES=4, TIMEOUT_CYCLES=50 on bench):
- Reset, then iReq=0000010 pulse at cycle 10 -> oFrameSel=1 after edge 10, oDrawEnable high from edge 12. Drawer done at cycle 30 -> oShownFrame=1, oShownValid=1, oBusy low 4 cycles after HOLD entry.
- iReq=0000101 and 1000000 in the same cycle -> grants in order 6, 2, 0, each with a full SETUP/DRAW/HOLD pass; pend=0 at the end.
- iReq bit 3 pulsed during DRAW and HOLD of frame 1 -> exactly one subsequent draw of frame 3, starting right after HOLD.
- Never pulse iDrawDone -> oTimeout=1 at DRAW cycle 50, state IDLE, oShownFrame unchanged. iClearErr clears it; simultaneous timeout and done -> oTimeout stays 0.
- Assert iReset mid-DRAW -> all outputs 0 and pend=0 asynchronously; a request pending at reset is not serviced afterwards.
- With FRAME_DEDUP_EN: request frame 4 twice after it is shown -> no second oDrawEnable pulse. Without the macro -> second full draw.

Source files
------------

// File: rtl/whack_draw_pkg.sv
// Shared definitions for the whack-a-mole full-screen draw scheduler.
//   FRAME_W       : width of a frame ID
//   FRM_*         : frame IDs; a higher ID has higher draw priority
//   draw_state_e  : scheduler states (idle / select settle / drawing / hold)
package whack_draw_pkg;

  localparam int unsigned FRAME_W = 3;

  localparam int unsigned FRM_START    = 0;
  localparam int unsigned FRM_GAME     = 1;
  localparam int unsigned FRM_MOLE1    = 2;
  localparam int unsigned FRM_MOLE2    = 3;
  localparam int unsigned FRM_MOLE3    = 4;
  localparam int unsigned FRM_MOLE4    = 5;
  localparam int unsigned FRM_GAMEOVER = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_HOLD
  } draw_state_e;

endpackage

// File: rtl/draw_priority_enc.sv
// Combinational highest-index priority encoder.
//   req_i    : request vector, bit i = frame ID i
//   valid_o  : at least one request bit is set
//   id_o     : binary ID of the highest set bit (0 when none)
//   onehot_o : one-hot mask of that bit (all zero when none)
module draw_priority_enc #(
  parameter int unsigned NUM_FRAMES = 7,
  parameter int unsigned FRAME_W    = 3
) (
  input  logic [NUM_FRAMES-1:0] req_i,
  output logic                  valid_o,
  output logic [FRAME_W-1:0]    id_o,
  output logic [NUM_FRAMES-1:0] onehot_o
);

  // Ascending scan: the last hit, i.e. the highest index, is what remains.
  always_comb begin
    id_o     = '0;
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
      if (req_i[i]) begin
        id_o        = FRAME_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Redraw scheduler between the game FSM and the full-screen image drawer.
// Latches per-frame redraw requests, grants the highest frame ID, holds the
// frame select stable for SETUP_CYCLES, enables the drawer until it reports
// done (or the watchdog expires), then holds the image for HOLD_CYCLES.
//   iClock, iReset : clock, asynchronous active-high reset
//   iReq           : per-frame redraw request pulses
//   iDrawDone      : drawer completion pulse (ignored outside DRAW)
//   iClearErr      : clears the sticky watchdog flag
//   oFrameSel      : frame ID to render, changes only on a grant
//   oDrawEnable    : high for the whole DRAW state
//   oBusy          : high whenever not IDLE
//   oShownFrame/oShownValid : last frame drawn to completion
//   oTimeout       : sticky drawer-hang flag
// Build option: FRAME_DEDUP_EN drops a winning request whose frame is already
// on screen instead of redrawing it.
module frame_draw_scheduler
  import whack_draw_pkg::*;
#(
  parameter int unsigned NUM_FRAMES     = 7,
  parameter int unsigned FRAME_W        = whack_draw_pkg::FRAME_W,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic [NUM_FRAMES-1:0] iReq,
  input  logic                  iDrawDone,
  input  logic                  iClearErr,
  output logic [FRAME_W-1:0]    oFrameSel,
  output logic                  oDrawEnable,
  output logic                  oBusy,
  output logic [FRAME_W-1:0]    oShownFrame,
  output logic                  oShownValid,
  output logic                  oTimeout
);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  draw_state_e             state_q, state_d;
  logic [NUM_FRAMES-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0]      sel_q, sel_d;
  logic                    en_q, en_d;
  logic                    busy_q, busy_d;
  logic [FRAME_W-1:0]      shown_q, shown_d;
  logic                    shown_vld_q, shown_vld_d;
  logic                    tout_q, tout_d;

  logic [NUM_FRAMES-1:0]   cand;
  logic [NUM_FRAMES-1:0]   grant;
  logic                    win_valid;
  logic [FRAME_W-1:0]      win_id;
  logic [NUM_FRAMES-1:0]   win_onehot;
  logic                    dedup_hit;

  // Requests arriving this cycle take part in arbitration immediately.
  assign cand = pend_q | iReq;

  draw_priority_enc #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_W    (FRAME_W)
  ) u_enc (
    .req_i    (cand),
    .valid_o  (win_valid),
    .id_o     (win_id),
    .onehot_o (win_onehot)
  );

`ifdef FRAME_DEDUP_EN
  assign dedup_hit = shown_vld_q && (win_id == shown_q);
`else
  assign dedup_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    en_d        = en_q;
    shown_d     = shown_q;
    shown_vld_d = shown_vld_q;
    tout_d      = tout_q & ~iClearErr;
    grant       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant = win_onehot;
          if (!dedup_hit) begin
            sel_d   = win_id;
            cnt_d   = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = S_DRAW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAW: begin
        // Done takes precedence over a watchdog expiry in the same cycle.
        if (iDrawDone) begin
          shown_d     = sel_q;
          shown_vld_d = 1'b1;
          en_d        = 1'b0;
          cnt_d       = '0;
          state_d     = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          tout_d  = 1'b1;
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A bit that was already pending and is requested again in its own
    // grant cycle stays set; a fresh pulse that wins is consumed.
    pend_d = cand & ~(grant & ~(pend_q & iReq));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= FRAME_W'(FRM_START);
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      shown_q     <= '0;
      shown_vld_q <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      shown_q     <= shown_d;
      shown_vld_q <= shown_vld_d;
      tout_q      <= tout_d;
    end
  end

  assign oFrameSel   = sel_q;
  assign oDrawEnable = en_q;
  assign oBusy       = busy_q;
  assign oShownFrame = shown_q;
  assign oShownValid = shown_vld_q;
  assign oTimeout    = tout_q;

endmodule
